// File: rtl/button_pio_pkg.sv
// Register map of the button PIO slave and the state encoding shared by the
// interrupt-servicing initiator and its bench.
package button_pio_pkg;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_MASK = 2'd2;
    localparam logic [1:0] REG_EDGE = 2'd3;

    typedef enum logic [3:0] {
        INIT_MASK,
        WAIT_IRQ,
        RD_EDGE,
        RD_EDGE_WAIT,
        CLR_EDGE,
        RD_DATA,
        RD_DATA_WAIT,
        UPDATE,
        HOLDOFF
    } state_t;

endpackage

// File: rtl/button_irq_master_if.sv
// Avalon-MM bundle between the button initiator and the PIO s1 port.
// Handshake: a beat is accepted in the first cycle with avm_chipselect=1 and
// avm_waitrequest=0; address/write_n/writedata hold from assertion to acceptance.
interface button_irq_master_if #(
    parameter int ADDR_W = 2
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_write_n;
    logic [31:0]       avm_writedata;
    logic [31:0]       avm_readdata;
    logic              avm_waitrequest;

    modport master (
        output avm_address, avm_chipselect, avm_write_n, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
        output avm_readdata, avm_waitrequest
    );
endinterface

// File: rtl/avmm_single_xfer.sv
// Issues one Avalon-MM beat per start request, holds it through waitrequest,
// and flags the read data READ_LATENCY cycles after acceptance.
module avmm_single_xfer #(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              accepted,
    output logic              rdata_valid,
    output logic              rdata_bit,
    button_irq_master_if.master bus
);
    logic       pending;
    logic [1:0] lat_cnt;

    assign accepted    = bus.avm_chipselect && !bus.avm_waitrequest;
    assign rdata_valid = pending && (lat_cnt == 2'(READ_LATENCY - 1));
    assign rdata_bit   = bus.avm_readdata[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.avm_chipselect <= 1'b0;
            bus.avm_write_n    <= 1'b1;
            bus.avm_address    <= '0;
            bus.avm_writedata  <= '0;
            pending            <= 1'b0;
            lat_cnt            <= 2'd0;
        end else begin
            if (accepted) begin
                bus.avm_chipselect <= 1'b0;
                if (bus.avm_write_n) begin
                    pending <= 1'b1;
                    lat_cnt <= 2'd0;
                end
            end else if (start && !bus.avm_chipselect && !pending) begin
                bus.avm_chipselect <= 1'b1;
                bus.avm_write_n    <= !wr;
                bus.avm_address    <= addr;
                bus.avm_writedata  <= wr ? wdata : 32'h0;
            end
            // Read outstanding: count cycles until the slave's data is due.
            if (pending) begin
                if (lat_cnt == 2'(READ_LATENCY - 1)) pending <= 1'b0;
                else                                  lat_cnt <= lat_cnt + 2'd1;
            end
        end
    end
endmodule

// File: rtl/button_irq_master.sv
// Services the button PIO interrupt in hardware: masks it on, then per irq reads
// and clears the edge capture, reads the pin, and publishes a press count.
module button_irq_master
    import button_pio_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int CNT_W        = 16,
    parameter int ADDR_W       = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             irq,
    button_irq_master_if.master avm,
    output logic [CNT_W-1:0] press_count,
    output logic             pin_level,
    output logic             event_pulse,
    output logic             busy,
    output state_t           fsm_state
);
    logic              issued;
    logic              start;
    logic              xfer_state;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              accepted;
    logic              rdata_valid;
    logic              rdata_bit;
    logic              data_bit;
    logic              hold_cnt;

    always_comb begin
        xfer_state = 1'b1;
        req_wr     = 1'b0;
        req_addr   = ADDR_W'(REG_DATA);
        req_wdata  = 32'h0;
        case (fsm_state)
            INIT_MASK: begin
                req_wr    = 1'b1;
                req_addr  = ADDR_W'(REG_MASK);
                req_wdata = 32'h1;
            end
            RD_EDGE:  req_addr = ADDR_W'(REG_EDGE);
            CLR_EDGE: begin
                req_wr   = 1'b1;
                req_addr = ADDR_W'(REG_EDGE);
            end
            RD_DATA:  req_addr = ADDR_W'(REG_DATA);
            default:  xfer_state = 1'b0;
        endcase
    end

    // One request per transfer state; issued clears when the beat is accepted.
    assign start = xfer_state && !issued;

    avmm_single_xfer #(
        .READ_LATENCY(READ_LATENCY),
        .ADDR_W      (ADDR_W)
    ) u_xfer (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .wr         (req_wr),
        .addr       (req_addr),
        .wdata      (req_wdata),
        .accepted   (accepted),
        .rdata_valid(rdata_valid),
        .rdata_bit  (rdata_bit),
        .bus        (avm)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_state   <= INIT_MASK;
            issued      <= 1'b0;
            press_count <= '0;
            pin_level   <= 1'b0;
            event_pulse <= 1'b0;
            busy        <= 1'b1;
            data_bit    <= 1'b0;
            hold_cnt    <= 1'b0;
        end else begin
            event_pulse <= 1'b0;
            if (accepted)   issued <= 1'b0;
            else if (start) issued <= 1'b1;
            case (fsm_state)
                INIT_MASK: if (accepted) begin
                    fsm_state <= WAIT_IRQ;
                    busy      <= 1'b0;
                end
                WAIT_IRQ: if (irq && enable) begin
                    fsm_state <= RD_EDGE;
                    busy      <= 1'b1;
                end
                RD_EDGE: if (accepted) fsm_state <= RD_EDGE_WAIT;
                RD_EDGE_WAIT: if (rdata_valid) begin
                    fsm_state <= rdata_bit ? CLR_EDGE : HOLDOFF;
                    hold_cnt  <= 1'b0;
                end
                CLR_EDGE: if (accepted) fsm_state <= RD_DATA;
                RD_DATA:  if (accepted) fsm_state <= RD_DATA_WAIT;
                RD_DATA_WAIT: if (rdata_valid) begin
                    data_bit  <= rdata_bit;
                    fsm_state <= UPDATE;
                end
                UPDATE: begin
                    press_count <= press_count + CNT_W'(1);
                    pin_level   <= data_bit;
                    event_pulse <= 1'b1;
                    hold_cnt    <= 1'b0;
                    fsm_state   <= HOLDOFF;
                end
                // Two cycles for the slave's registered irq to fall after the clear.
                HOLDOFF: begin
                    if (hold_cnt) begin
                        fsm_state <= WAIT_IRQ;
                        busy      <= 1'b0;
                    end else begin
                        hold_cnt <= 1'b1;
                    end
                end
                default: begin
                    fsm_state <= INIT_MASK;
                    busy      <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_button_irq_master.sv
// Bench for button_irq_master against a behavioural button PIO slave with
// configurable waitrequest stalls and a scoreboard of expected bus beats.
module tb_button_irq_master;
    import button_pio_pkg::*;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             enable = 1'b1;
    logic             irq;
    logic             in_port = 1'b1;
    logic             irq_force = 1'b0;
    int               ws_cfg = 0;
    logic [CNT_W-1:0] press_count;
    logic             pin_level;
    logic             event_pulse;
    logic             busy;
    state_t           fsm_state;

    button_irq_master_if #(.ADDR_W(2)) avm ();

    always #5 clk = ~clk;

    button_irq_master #(
        .READ_LATENCY(1),
        .CNT_W       (CNT_W),
        .ADDR_W      (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .irq        (irq),
        .avm        (avm),
        .press_count(press_count),
        .pin_level  (pin_level),
        .event_pulse(event_pulse),
        .busy       (busy),
        .fsm_state  (fsm_state)
    );

    // PIO slave model: falling-edge capture, clear-on-write, registered irq and readdata.
    logic [31:0] rd_q;
    logic        mask_q, edge_q, prev_in, slave_irq, acc, edge_n;
    int          ws_cnt;

    assign avm.avm_waitrequest = avm.avm_chipselect && (ws_cnt != ws_cfg);
    assign avm.avm_readdata    = rd_q;
    assign irq                 = slave_irq | irq_force;

    always_comb begin
        acc    = avm.avm_chipselect && !avm.avm_waitrequest;
        edge_n = edge_q | (prev_in & ~in_port);
        if (acc && !avm.avm_write_n && avm.avm_address == REG_EDGE) edge_n = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q    <= 1'b0;
            edge_q    <= 1'b0;
            prev_in   <= 1'b1;
            slave_irq <= 1'b0;
            rd_q      <= 32'h0;
            ws_cnt    <= 0;
        end else begin
            prev_in   <= in_port;
            edge_q    <= edge_n;
            slave_irq <= edge_n & mask_q;
            if (acc) ws_cnt <= 0;
            else if (avm.avm_chipselect) ws_cnt <= ws_cnt + 1;
            if (acc && !avm.avm_write_n && avm.avm_address == REG_MASK) mask_q <= avm.avm_writedata[0];
            if (acc && avm.avm_write_n) begin
                case (avm.avm_address)
                    REG_DATA: rd_q <= {31'b0, in_port};
                    REG_MASK: rd_q <= {31'b0, mask_q};
                    REG_EDGE: rd_q <= {31'b0, edge_q};
                    default:  rd_q <= 32'h0;
                endcase
            end
        end
    end

    // Scoreboard and bus monitor.
    logic [34:0]      exp_q[$];
    int               compared = 0;
    int               mismatched = 0;
    int               beats = 0;
    int               events = 0;
    int               holds = 0;
    logic [CNT_W-1:0] exp_count = '0;
    logic             hold_v = 1'b0;
    logic [34:0]      hold_b, obs, exp_b;

    function automatic logic [34:0] beat(input logic wn, input logic [1:0] a, input logic [31:0] d);
        return {wn, a, (wn ? 32'h0 : d)};
    endfunction

    always @(negedge clk) begin
        obs = beat(avm.avm_write_n, avm.avm_address, avm.avm_writedata);
        if (hold_v && avm.avm_chipselect) begin
            holds++;
            compared++;
            if (obs !== hold_b) begin
                mismatched++;
                $display("FAIL hold_stable: got %h expected %h", obs, hold_b);
            end
        end
        if (avm.avm_chipselect && !avm.avm_waitrequest) begin
            beats++;
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_beat: got %h expected none", obs);
            end else begin
                exp_b = exp_q.pop_front();
                if (obs !== exp_b) begin
                    mismatched++;
                    $display("FAIL beat: got %h expected %h", obs, exp_b);
                end
            end
        end
        hold_v = avm.avm_chipselect && avm.avm_waitrequest;
        hold_b = obs;
        if (event_pulse) events++;
    end

    task automatic wait_busy(input logic lvl, input int budget, input string name);
        int n = 0;
        while (busy !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy !== lvl) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: busy got %b expected %b", name, busy, lvl);
        end
    endtask

    task automatic wait_events(input int target, input int budget, input string name);
        int n = 0;
        while (events < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (events < target) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: events got %0d expected %0d", name, events, target);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset;
        #3 reset_n = 1'b0;
        #1;
        check_int("rst_chipselect", int'(avm.avm_chipselect), 0);
        check_int("rst_write_n", int'(avm.avm_write_n), 1);
        check_int("rst_address", int'(avm.avm_address), 0);
        check_int("rst_writedata", int'(avm.avm_writedata), 0);
        check_int("rst_press_count", int'(press_count), 0);
        check_int("rst_pin_level", int'(pin_level), 0);
        check_int("rst_event_pulse", int'(event_pulse), 0);
        check_int("rst_busy", int'(busy), 1);
        exp_q.push_back(beat(1'b0, REG_MASK, 32'h1));
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_busy(1'b0, 50, "init");
        repeat (20) @(negedge clk);
        check_int("init_beats", beats, 1);
        check_int("init_queue", exp_q.size(), 0);
        check_int("init_idle_busy", int'(busy), 0);
    endtask

    // One falling edge on the pin; expects the three-beat service sequence.
    task automatic do_press(input string name, input int exp_holds);
        int b0 = beats;
        int e0 = events;
        int h0 = holds;
        exp_count = exp_count + CNT_W'(1);
        exp_q.push_back(beat(1'b1, REG_EDGE, 32'h0));
        exp_q.push_back(beat(1'b0, REG_EDGE, 32'h0));
        exp_q.push_back(beat(1'b1, REG_DATA, 32'h0));
        in_port = 1'b0;
        wait_events(e0 + 1, 200, name);
        @(negedge clk);
        check_int({name, "_count"}, int'(press_count), int'(exp_count));
        check_int({name, "_pin_level"}, int'(pin_level), 0);
        wait_busy(1'b0, 50, name);
        repeat (5) @(negedge clk);
        check_int({name, "_events"}, events - e0, 1);
        check_int({name, "_irq"}, int'(irq), 0);
        check_int({name, "_beats"}, beats - b0, 3);
        check_int({name, "_holds"}, holds - h0, exp_holds);
        check_int({name, "_queue"}, exp_q.size(), 0);
        in_port = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_press;
        do_press("press", 0);
    endtask

    task automatic test_waitrequest;
        ws_cfg = 3;
        do_press("wait3", 9);
        ws_cfg = 0;
    endtask

    task automatic test_spurious;
        int b0 = beats;
        int e0 = events;
        int n = 0;
        exp_q.push_back(beat(1'b1, REG_EDGE, 32'h0));
        irq_force = 1'b1;
        while (beats == b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        irq_force = 1'b0;
        wait_busy(1'b0, 50, "spur");
        repeat (10) @(negedge clk);
        check_int("spur_beats", beats - b0, 1);
        check_int("spur_events", events - e0, 0);
        check_int("spur_count", int'(press_count), int'(exp_count));
        check_int("spur_queue", exp_q.size(), 0);
    endtask

    task automatic test_wrap;
        force dut.press_count = 16'hFFFF;
        @(negedge clk);
        release dut.press_count;
        @(negedge clk);
        check_int("wrap_preload", int'(press_count), 16'hFFFF);
        exp_count = 16'hFFFF;
        do_press("wrap", 0);
    endtask

    task automatic test_reset_mid;
        int b0 = beats;
        int e0 = events;
        int n = 0;
        ws_cfg = 20;
        exp_q.push_back(beat(1'b1, REG_EDGE, 32'h0));
        in_port = 1'b0;
        while (!(avm.avm_chipselect && !avm.avm_write_n && avm.avm_address == REG_EDGE) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_int("mid_clr_pending", int'(avm.avm_chipselect && !avm.avm_write_n), 1);
        repeat (2) @(negedge clk);
        #2;
        reset_n = 1'b0;
        in_port = 1'b1;
        #1;
        check_int("mid_chipselect", int'(avm.avm_chipselect), 0);
        check_int("mid_busy", int'(busy), 1);
        ws_cfg = 0;
        exp_q.push_back(beat(1'b0, REG_MASK, 32'h1));
        @(negedge clk);
        reset_n = 1'b1;
        wait_busy(1'b0, 50, "mid");
        repeat (10) @(negedge clk);
        check_int("mid_count", int'(press_count), 0);
        check_int("mid_beats", beats - b0, 2);
        check_int("mid_events", events - e0, 0);
        check_int("mid_queue", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_press();
        test_waitrequest();
        test_spurious();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
